// File: rtl/if_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package if_pkg;

  localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam int unsigned PC_STEP    = 4;

  // Position of the next byte inside the word being assembled (0 = MSB byte).
  typedef logic [1:0] byte_cnt_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// IF-stage bus: debug/decode controls in, instruction/PC and loader status out.
// master = fetch unit side, slave = decode/debug side.
interface if_fetch_unit_if #(
  parameter int PC_SIZE  = 32,
  parameter int BUS_SIZE = 32
);

  logic                i_enable;
  logic                i_stall;
  logic                i_next_pc_source;
  logic [PC_SIZE-1:0]  i_next_not_seq_pc;
  logic                i_inst_write_enable;
  logic [7:0]          i_inst_byte;
  logic [BUS_SIZE-1:0] o_instruction;
  logic [PC_SIZE-1:0]  o_next_seq_pc;
  logic [PC_SIZE-1:0]  o_pc;
  logic                o_halt;
  logic                o_mem_full;
  logic                o_mem_empty;

  modport master (
    input  i_enable, i_stall, i_next_pc_source, i_next_not_seq_pc,
           i_inst_write_enable, i_inst_byte,
    output o_instruction, o_next_seq_pc, o_pc, o_halt, o_mem_full, o_mem_empty
  );

  modport slave (
    output i_enable, i_stall, i_next_pc_source, i_next_not_seq_pc,
           i_inst_write_enable, i_inst_byte,
    input  o_instruction, o_next_seq_pc, o_pc, o_halt, o_mem_full, o_mem_empty
  );

endinterface

// File: rtl/if_inst_loader.sv
// Byte-serial instruction loader: assembles big-endian words from byte
// strobes and hands each completed word to the memory in the fetch unit.
// The pointer is one bit wider than the address so "full" is its MSB.
module if_inst_loader
  import if_pkg::*;
#(
  parameter int BUS_SIZE       = 32,
  parameter int MEM_SIZE_WORDS = 64,
  localparam int AW            = $clog2(MEM_SIZE_WORDS)
) (
  input  logic                clk,
  input  logic                srst,
  input  logic                byte_strobe,
  input  logic [7:0]          byte_in,
  output logic                wr_en,
  output logic [AW-1:0]       wr_addr,
  output logic [BUS_SIZE-1:0] wr_data,
  output logic                full,
  output logic                empty
);

  byte_cnt_t           cnt_reg,   cnt_next;
  logic [BUS_SIZE-9:0] asm_reg,   asm_next;
  logic [AW:0]         ptr_reg,   ptr_next;
  logic                empty_reg, empty_next;
  logic                accept;

  assign full    = ptr_reg[AW];
  assign empty   = empty_reg;
  assign accept  = byte_strobe && !full;
  assign wr_en   = accept && (cnt_reg == 2'd3);
  assign wr_addr = ptr_reg[AW-1:0];
  assign wr_data = {asm_reg, byte_in};

  // Next-state: shift accepted bytes in, advance pointer on the 4th byte.
  always_comb begin
    cnt_next   = cnt_reg;
    asm_next   = asm_reg;
    ptr_next   = ptr_reg;
    empty_next = empty_reg;
    if (accept) begin
      empty_next = 1'b0;
      cnt_next   = cnt_reg + 2'd1;
      asm_next   = {asm_reg[BUS_SIZE-17:0], byte_in};
      if (cnt_reg == 2'd3) begin
        ptr_next = ptr_reg + 1'b1;
      end
    end
  end

  // Loader state registers; reset discards any partial word.
  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_reg   <= '0;
      asm_reg   <= '0;
      ptr_reg   <= '0;
      empty_reg <= 1'b1;
    end else begin
      cnt_reg   <= cnt_next;
      asm_reg   <= asm_next;
      ptr_reg   <= ptr_next;
      empty_reg <= empty_next;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// MIPS32 instruction-fetch stage: PC register, word-addressed instruction
// memory filled by the byte loader, combinational fetch from the current PC.
// Optional feature macro IF_HALT_DETECT_EN: when defined, fetching the HALT
// word freezes the PC and raises o_halt until reset; otherwise o_halt is 0.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter int PC_SIZE        = 32,
  parameter int BUS_SIZE       = 32,
  parameter int MEM_SIZE_WORDS = 64
) (
  input  logic            i_clk,
  input  logic            i_reset,
  if_fetch_unit_if.master bus
);

  localparam int AW = $clog2(MEM_SIZE_WORDS);

  logic [BUS_SIZE-1:0] mem_reg [MEM_SIZE_WORDS];
  logic [PC_SIZE-1:0]  pc_reg, pc_next;
  logic [AW-1:0]       fetch_idx;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [BUS_SIZE-1:0] wr_data;

  if_inst_loader #(
    .BUS_SIZE       (BUS_SIZE),
    .MEM_SIZE_WORDS (MEM_SIZE_WORDS)
  ) u_loader (
    .clk         (i_clk),
    .srst        (i_reset),
    .byte_strobe (bus.i_inst_write_enable),
    .byte_in     (bus.i_inst_byte),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .full        (bus.o_mem_full),
    .empty       (bus.o_mem_empty)
  );

  // Each word clears to NOP on reset and takes loader data when addressed.
  // A word written this edge is seen by fetch only from the next cycle.
  for (genvar gi = 0; gi < MEM_SIZE_WORDS; gi++) begin : g_mem
    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        mem_reg[gi] <= BUS_SIZE'(NOP_INSTR);
      end else if (wr_en && (wr_addr == AW'(gi))) begin
        mem_reg[gi] <= wr_data;
      end
    end
  end

  // Low two PC bits are ignored; upper bits alias so fetch wraps.
  assign fetch_idx         = pc_reg[AW+1:2];
  assign bus.o_instruction = mem_reg[fetch_idx];
  assign bus.o_pc          = pc_reg;
  assign bus.o_next_seq_pc = pc_reg + PC_SIZE'(PC_STEP);

`ifdef IF_HALT_DETECT_EN
  logic halt_reg, halt_next;
  assign bus.o_halt = halt_reg;

  // PC/halt next-state; detecting HALT freezes the PC at the HALT address.
  always_comb begin
    pc_next   = pc_reg;
    halt_next = halt_reg;
    if (halt_reg || !bus.i_enable) begin
      pc_next = pc_reg;
    end else if (bus.o_instruction == BUS_SIZE'(HALT_INSTR)) begin
      halt_next = 1'b1;
    end else if (bus.i_stall) begin
      pc_next = pc_reg;
    end else if (bus.i_next_pc_source) begin
      pc_next = bus.i_next_not_seq_pc;
    end else begin
      pc_next = bus.o_next_seq_pc;
    end
  end

  // PC and halt flag registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pc_reg   <= '0;
      halt_reg <= 1'b0;
    end else begin
      pc_reg   <= pc_next;
      halt_reg <= halt_next;
    end
  end
`else
  assign bus.o_halt = 1'b0;

  // PC next-state: stall drops a concurrent redirect, decode re-presents it.
  always_comb begin
    pc_next = pc_reg;
    if (!bus.i_enable || bus.i_stall) begin
      pc_next = pc_reg;
    end else if (bus.i_next_pc_source) begin
      pc_next = bus.i_next_not_seq_pc;
    end else begin
      pc_next = bus.o_next_seq_pc;
    end
  end

  // PC register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pc_reg <= '0;
    end else begin
      pc_reg <= pc_next;
    end
  end
`endif

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage of the MIPS32 pipeline; it is the producer side of the decode stage's instruction/PC interface. It holds the PC and a word-addressed instruction memory, which the debug unit loads one byte at a time. Each cycle it presents the instruction and PC+4 to the IF/ID boundary. It also consumes the branch/jump redirect (`next_pc_source`, `next_not_seq_pc`) that the decode stage resolves.

## Interface
- `PC_SIZE`, 32, PC and PC-derived bus width
- `BUS_SIZE`, 32, instruction word width
- `MEM_SIZE_WORDS`, 64, instruction memory depth in words; must be a power of 2
- `i_clk`  in  1  clock; all state changes on its rising edge
- `i_reset`  in  1  synchronous, active-high reset
- `i_enable`  in  1  pipeline run enable from debug unit; 0 freezes PC
- `i_stall`  in  1  hazard stall; holds PC
- `i_next_pc_source`  in  1  1 selects `i_next_not_seq_pc`, 0 selects PC+4
- `i_next_not_seq_pc`  in  PC_SIZE  branch/jump target from decode
- `i_inst_write_enable`  in  1  loader byte strobe
- `i_inst_byte`  in  8  loader byte
- `o_instruction`  out  BUS_SIZE  `mem[o_pc[AW+1:2]]`, where AW = clog2(MEM_SIZE_WORDS)
- `o_next_seq_pc`  out  PC_SIZE  `o_pc + 4`
- `o_pc`  out  PC_SIZE  current PC
- `o_halt`  out  1  HALT fetched, PC frozen (see Configuration)
- `o_mem_full`  out  1  loader has written all words
- `o_mem_empty`  out  1  no byte accepted since reset

## Operation
- **Reset values:**
  - `o_pc` = 0, `o_next_seq_pc` = 4.
  - All memory words cleared to 0 (NOP), so `o_instruction` = 0.
  - `o_halt` = 0, `o_mem_full` = 0, `o_mem_empty` = 1.
  - Loader byte count and word pointer = 0.
- **PC update priority, per edge:**
  1. Reset.
  2. `o_halt` = 1: hold.
  3. `i_enable` = 0: hold.
  4. `i_stall` = 1: hold; a redirect asserted in the same cycle is dropped, because decode re-presents it.
  5. `i_next_pc_source` = 1: PC ← `i_next_not_seq_pc`.
  6. Otherwise: PC ← PC + 4.
- **Address arithmetic:**
  - PC add is modulo 2^PC_SIZE.
  - Fetch index is `o_pc[AW+1:2]`. Low two bits are ignored; upper bits alias, so the fetch address wraps modulo memory size.
- **Loader:**
  - Bytes are assembled big-endian: 1st byte → [31:24], 4th byte → [7:0].
  - On the 4th byte the word is written to `mem[ptr]` and `ptr` increments.
  - `o_mem_empty` clears on the first accepted byte.
  - `o_mem_full` sets when `ptr` reaches MEM_SIZE_WORDS. Bytes arriving while full are ignored; there is no wrap.
  - Loads are accepted regardless of `i_enable`.
  - If the word being written is also being fetched in the same cycle, the fetch returns the old value; the new value is visible the next cycle.

## Timing
- Fetch is combinational from the registered PC: `o_instruction` and `o_next_seq_pc` are valid in the same cycle as `o_pc`, with 0-cycle latency.
- A redirect is a 1-cycle path: it is sampled at edge N, and the new `o_pc` is visible after edge N.
- A loader word is visible to fetch on the cycle after the 4th byte's edge.
- Reset mid-load discards the partial word and restarts at word 0.
- Reset mid-run returns PC to 0 and clears `o_halt`.

## Configuration
- Macro: `IF_HALT_DETECT_EN`.
- **Defined:**
  - When `i_enable` = 1, `o_halt` = 0, and `o_instruction` == HALT (32'hFFFFFFFF), `o_halt` sets at the next edge.
  - The PC holds at the HALT address until reset.
  - The HALT word keeps being presented.
- **Undefined:**
  - `o_halt` is tied to 0.
  - HALT is treated as an ordinary word and the PC advances.

## Structure
- **Package `if_pkg`:** `HALT_INSTR` = 32'hFFFFFFFF, `NOP_INSTR` = 0, `PC_STEP` = 4, and the loader byte-count type (2 bits).
- **Sub-module `if_inst_loader`:**
  - Contains the byte assembler, word pointer (AW+1 bits), and full/empty flags.
  - Outputs the write strobe, address, and data to the memory array in `if_fetch_unit`.

## Test plan
- **Load, then run (HALT not reached):**
  - Load bytes 00,22,18,20 then FF,FF,FF,FF → word0 = 0x00221820, word1 = 0xFFFFFFFF; `o_mem_empty` falls after the 1st byte.
  - Set `i_enable` = 1 → `o_pc` = 0, `o_instruction` = 0x00221820, `o_next_seq_pc` = 4.
- **HALT detection (`IF_HALT_DETECT_EN` defined):**
  - After the next edge → `o_pc` = 4, `o_instruction` = 0xFFFFFFFF.
  - After one further edge → `o_halt` = 1; `o_pc` stays 4 for 5 more cycles.
- **Redirect and stall:**
  - `i_next_pc_source` = 1, `i_next_not_seq_pc` = 0x10 → `o_pc` = 0x10 the next cycle.
  - The same stimulus with `i_stall` = 1 → `o_pc` unchanged.
- **Full:** load 256 bytes (MEM_SIZE_WORDS = 64) → `o_mem_full` = 1 after the 256th byte; a 257th byte (0xAB) leaves word0 unchanged.
- **Reset mid-load:** load 2 bytes, pulse `i_reset` → `o_mem_empty` = 1; the next 4 bytes 12,34,56,78 give word0 = 0x12345678.
- **Address wrap:** `i_next_not_seq_pc` = 0xFC → `o_pc` = 0xFC fetches word 63; the next edge gives `o_pc` = 0x100, which fetches word 0.
